duck_game_sequencer: RTL and testbench
======================================

# duck_game_sequencer

Frame-synchronous game controller for the Duck Hunt datapath. It sits between the VGA frame timing, the zapper inputs (trigger, photodiode) and the duck renderer/pattern generator. It owns the duck life cycle: spawn, fly, shot flash (black frame then target-white frame), hit/fall, escape, pause. It also owns shot, hit, round and score bookkeeping, and drives the renderer's speed and flash-mode controls.

## Interface
- SHOTS_PER_DUCK, 3: shots granted per duck (1..3).
- DUCKS_PER_ROUND, 10: ducks per round (1..15).
- PASS_HITS, 6: hits needed in a round to advance.
- FLIGHT_FRAMES, 300: frames a duck flies before escaping (1..511).
- PAUSE_FRAMES, 60: frames between ducks (1..255).
- SPEED_INIT, 2 / SPEED_STEP, 1 / SPEED_MAX, 15: renderer step size, pixels/frame.
- HIT_POINTS, 100: score per hit.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per frame at start of vblank; all state transitions happen only on cycles where this is high.
- trigger  in  1  debounced zapper trigger, level.
- detect  in  1  photodiode, level.
- duck_landed  in  1  renderer: falling duck reached ground, level.
- flash  out  2  00 normal, 01 all-black frame, 10 target-white frame.
- duck_fly  out  1  renderer moves duck while high.
- duck_spawn / duck_shot / duck_escape  out  1 each  one-clk event pulses to renderer.
- speed  out  6  renderer step size.
- shots_left  out  2; hits  out  4; duck_idx  out  4; round  out  8; score  out  16.
- game_over  out  1.

## Operation
- Trigger edge: trig_prev is sampled on every frame_tick. An edge is trigger & ~trig_prev at frame_tick. A held trigger gives exactly one edge. Edges in states other than FLY, IDLE and GAME_OVER are discarded.
- detect_seen: cleared on entry to WHITE. It is set on any clk in WHITE with detect=1, including the closing frame_tick cycle. detect outside WHITE is ignored.
- IDLE: flash=00, outputs hold.
  - Edge → FLY.
  - Loads score=0, round=1, speed=SPEED_INIT, hits=0, duck_idx=0.
  - Spawn action (below).
- Spawn action: duck_spawn pulse, shots_left=SHOTS_PER_DUCK, flight_timer=0.
- FLY: duck_fly=1. Evaluated in priority order:
  - Edge with shots_left>0 → BLACK; shots_left−1.
  - Otherwise flight_timer+1. When it reaches FLIGHT_FRAMES → escape action.
  - Edge with shots_left=0 is ignored.
- BLACK: flash=01, duck_fly=0. Next frame_tick → WHITE.
- WHITE: flash=10, duck_fly=0. On frame_tick:
  - detect_seen → FALL; duck_shot pulse; hits+1; score += HIT_POINTS, saturating at 0xFFFF.
  - Else shots_left=0 → escape action.
  - Else → FLY; flight_timer resumes, flash frames not counted.
- FALL: duck_fly=0. frame_tick with duck_landed=1 → PAUSE, pause_timer=0.
- Escape action: duck_escape pulse → PAUSE, pause_timer=0.
- PAUSE: pause_timer+1 per frame_tick. On reaching PAUSE_FRAMES:
  - duck_idx < DUCKS_PER_ROUND−1 → duck_idx+1 → FLY with spawn action.
  - Else, hits ≥ PASS_HITS → round+1 (saturate 255), speed=min(speed+SPEED_STEP, SPEED_MAX), hits=0, duck_idx=0 → FLY with spawn action.
  - Else → GAME_OVER.
- GAME_OVER: game_over=1; score, round and hits hold. Edge → IDLE, game_over=0.

## Timing
- All registered outputs change in the clk after the frame_tick cycle that causes them. Exception: flash/duck_fly track state, so they also change one clk after frame_tick.
- Event pulses are high for exactly that one clk. There is at most one pulse per frame_tick.
- Shot latency, trigger edge to verdict:
  - Edge frame → BLACK frame → WHITE frame.
  - duck_shot/duck_escape is issued on the frame_tick ending WHITE, i.e. the 2nd frame_tick after the edge.
- Simultaneous events:
  - Trigger edge and flight timeout on the same frame_tick: the shot wins, timer not advanced.
  - duck_landed outside FALL is ignored.
- rst: synchronous, overrides frame_tick. Next clk values:
  - state=IDLE, flash=00, duck_fly=0, all pulses 0.
  - shots_left=0, hits=0, duck_idx=0, round=0, score=0, speed=SPEED_INIT, game_over=0.
  - trig_prev=0, timers=0, detect_seen=0.
  - Mid-game reset drops any in-flight flash/pulse.
- Counter widths: flight_timer 9b, pause_timer 8b. No wrap is possible within legal parameter ranges.

## Test plan
- Start + hit: in IDLE, trigger rises before frame_tick N.
  - One duck_spawn, shots_left=3.
  - Trigger edge at frame k → flash 01 for a frame, then 10 with detect=1.
  - On the next frame_tick: duck_shot, hits=1, score=100, state FALL.
  - duck_landed → PAUSE; 60 frames later, duck_spawn and duck_idx=1.
- Three misses: three trigger edges, detect=0.
  - shots_left goes 2, 1, 0.
  - After the third WHITE: duck_escape, no duck_shot, score unchanged.
- Timeout: no trigger for 300 frames in FLY → duck_escape on frame_tick 300.
  - Same-tick check: a trigger edge on tick 300 yields BLACK instead.
- Held trigger: trigger high for 20 frames → exactly one BLACK/WHITE sequence, shots_left−1 only once.
- Round pass/fail:
  - 6 hits in 10 ducks → round=2, speed=3, hits=0.
  - 5 hits → game_over=1, score held; next trigger edge → IDLE, game_over=0.
- Reset mid-WHITE with detect=1 → next clk flash=00, no duck_shot, score=0, state IDLE.

Source files
------------

// File: rtl/duck_game_sequencer.sv
// duck_game_sequencer: frame-synchronous Duck Hunt game controller.
// Owns the duck life cycle (spawn, fly, black/white shot flash, fall,
// escape, pause) plus shot/hit/round/score bookkeeping. Every state change
// is qualified by frame_tick. All outputs are registered.
module duck_game_sequencer #(
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6,
  parameter int FLIGHT_FRAMES   = 300,
  parameter int PAUSE_FRAMES    = 60,
  parameter int SPEED_INIT      = 2,
  parameter int SPEED_STEP      = 1,
  parameter int SPEED_MAX       = 15,
  parameter int HIT_POINTS      = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        trigger,
  input  logic        detect,
  input  logic        duck_landed,
  output logic [1:0]  flash,
  output logic        duck_fly,
  output logic        duck_spawn,
  output logic        duck_shot,
  output logic        duck_escape,
  output logic [5:0]  speed,
  output logic [1:0]  shots_left,
  output logic [3:0]  hits,
  output logic [3:0]  duck_idx,
  output logic [7:0]  round,
  output logic [15:0] score,
  output logic        game_over
);

  localparam logic [1:0]  SHOTS_INIT  = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]  LAST_DUCK   = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]  PASS_LIMIT  = 4'(PASS_HITS);
  localparam logic [8:0]  FLIGHT_LAST = 9'(FLIGHT_FRAMES);
  localparam logic [7:0]  PAUSE_LAST  = 8'(PAUSE_FRAMES);
  localparam logic [5:0]  SPD_INIT    = 6'(SPEED_INIT);
  localparam logic [6:0]  SPD_STEP    = 7'(SPEED_STEP);
  localparam logic [6:0]  SPD_MAX     = 7'(SPEED_MAX);
  localparam logic [16:0] POINTS      = 17'(HIT_POINTS);

  localparam logic [1:0] FLASH_NORMAL = 2'b00;
  localparam logic [1:0] FLASH_BLACK  = 2'b01;
  localparam logic [1:0] FLASH_WHITE  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLY,
    ST_BLACK,
    ST_WHITE,
    ST_FALL,
    ST_PAUSE,
    ST_GAME_OVER
  } state_t;

  state_t      state_reg;
  logic        trig_prev_reg;
  logic        detect_seen_reg;
  logic [8:0]  flight_timer_reg;
  logic [7:0]  pause_timer_reg;

  logic        trig_edge;
  logic        hit_now;
  logic [8:0]  flight_inc;
  logic [7:0]  pause_inc;
  logic [16:0] score_sum;
  logic [15:0] score_sat;
  logic [6:0]  speed_sum;
  logic [5:0]  speed_sat;
  logic [7:0]  round_sat;

  // Trigger edge is only meaningful on a frame_tick; a held trigger yields one edge.
  assign trig_edge  = frame_tick & trigger & ~trig_prev_reg;
  // Photodiode seen earlier in the white frame or on the closing tick itself.
  assign hit_now    = detect_seen_reg | detect;
  assign flight_inc = flight_timer_reg + 9'd1;
  assign pause_inc  = pause_timer_reg + 8'd1;
  assign score_sum  = {1'b0, score} + POINTS;
  assign score_sat  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign speed_sum  = {1'b0, speed} + SPD_STEP;
  assign speed_sat  = (speed_sum > SPD_MAX) ? SPD_MAX[5:0] : speed_sum[5:0];
  assign round_sat  = (round == 8'hFF) ? round : round + 8'd1;

  // Game FSM: state, bookkeeping counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      trig_prev_reg    <= 1'b0;
      detect_seen_reg  <= 1'b0;
      flight_timer_reg <= 9'd0;
      pause_timer_reg  <= 8'd0;
      flash            <= FLASH_NORMAL;
      duck_fly         <= 1'b0;
      duck_spawn       <= 1'b0;
      duck_shot        <= 1'b0;
      duck_escape      <= 1'b0;
      speed            <= SPD_INIT;
      shots_left       <= 2'd0;
      hits             <= 4'd0;
      duck_idx         <= 4'd0;
      round            <= 8'd0;
      score            <= 16'd0;
      game_over        <= 1'b0;
    end else begin
      duck_spawn  <= 1'b0;
      duck_shot   <= 1'b0;
      duck_escape <= 1'b0;

      if (frame_tick) begin
        trig_prev_reg <= trigger;
      end

      if (state_reg == ST_WHITE && detect) begin
        detect_seen_reg <= 1'b1;
      end

      if (frame_tick) begin
        case (state_reg)
          ST_IDLE: begin
            if (trig_edge) begin
              score            <= 16'd0;
              round            <= 8'd1;
              speed            <= SPD_INIT;
              hits             <= 4'd0;
              duck_idx         <= 4'd0;
              duck_spawn       <= 1'b1;
              shots_left       <= SHOTS_INIT;
              flight_timer_reg <= 9'd0;
              state_reg        <= ST_FLY;
              flash            <= FLASH_NORMAL;
              duck_fly         <= 1'b1;
            end
          end

          ST_FLY: begin
            // A shot outranks a flight timeout on the same tick.
            if (trig_edge && shots_left != 2'd0) begin
              shots_left <= shots_left - 2'd1;
              state_reg  <= ST_BLACK;
              flash      <= FLASH_BLACK;
              duck_fly   <= 1'b0;
            end else if (flight_inc == FLIGHT_LAST) begin
              flight_timer_reg <= flight_inc;
              duck_escape      <= 1'b1;
              pause_timer_reg  <= 8'd0;
              state_reg        <= ST_PAUSE;
              duck_fly         <= 1'b0;
            end else begin
              flight_timer_reg <= flight_inc;
            end
          end

          ST_BLACK: begin
            detect_seen_reg <= 1'b0;
            state_reg       <= ST_WHITE;
            flash           <= FLASH_WHITE;
          end

          ST_WHITE: begin
            flash <= FLASH_NORMAL;
            if (hit_now) begin
              duck_shot <= 1'b1;
              hits      <= hits + 4'd1;
              score     <= score_sat;
              state_reg <= ST_FALL;
            end else if (shots_left == 2'd0) begin
              duck_escape     <= 1'b1;
              pause_timer_reg <= 8'd0;
              state_reg       <= ST_PAUSE;
            end else begin
              state_reg <= ST_FLY;
              duck_fly  <= 1'b1;
            end
          end

          ST_FALL: begin
            if (duck_landed) begin
              pause_timer_reg <= 8'd0;
              state_reg       <= ST_PAUSE;
            end
          end

          ST_PAUSE: begin
            if (pause_inc == PAUSE_LAST) begin
              pause_timer_reg <= pause_inc;
              if (duck_idx < LAST_DUCK) begin
                duck_idx         <= duck_idx + 4'd1;
                duck_spawn       <= 1'b1;
                shots_left       <= SHOTS_INIT;
                flight_timer_reg <= 9'd0;
                state_reg        <= ST_FLY;
                duck_fly         <= 1'b1;
              end else if (hits >= PASS_LIMIT) begin
                round            <= round_sat;
                speed            <= speed_sat;
                hits             <= 4'd0;
                duck_idx         <= 4'd0;
                duck_spawn       <= 1'b1;
                shots_left       <= SHOTS_INIT;
                flight_timer_reg <= 9'd0;
                state_reg        <= ST_FLY;
                duck_fly         <= 1'b1;
              end else begin
                game_over <= 1'b1;
                state_reg <= ST_GAME_OVER;
              end
            end else begin
              pause_timer_reg <= pause_inc;
            end
          end

          ST_GAME_OVER: begin
            if (trig_edge) begin
              game_over <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end

          default: begin
            state_reg <= ST_IDLE;
            flash     <= FLASH_NORMAL;
            duck_fly  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duck_game_sequencer.sv
// Directed bench for duck_game_sequencer: event pulses are scored against a
// queue of expected events; state outputs are checked inline after each frame.
`timescale 1ns/1ps
module tb_duck_game_sequencer;

  localparam int SHOTS      = 3;
  localparam int DUCKS      = 10;
  localparam int PASS       = 6;
  localparam int FLIGHT     = 300;
  localparam int PAUSE      = 60;
  localparam int SPD_INIT   = 2;
  localparam int SPD_STEP   = 1;
  localparam int SPD_MAX    = 15;
  localparam int HIT_POINTS = 100;

  localparam logic [2:0] EV_SPAWN = 3'b100;
  localparam logic [2:0] EV_SHOT  = 3'b010;
  localparam logic [2:0] EV_ESC   = 3'b001;

  logic        clk = 1'b0;
  logic        rst, frame_tick, trigger, detect, duck_landed;
  logic [1:0]  flash;
  logic        duck_fly, duck_spawn, duck_shot, duck_escape;
  logic [5:0]  speed;
  logic [1:0]  shots_left;
  logic [3:0]  hits, duck_idx;
  logic [7:0]  round;
  logic [15:0] score;
  logic        game_over;

  always #5 clk = ~clk;

  duck_game_sequencer #(
    .SHOTS_PER_DUCK(SHOTS), .DUCKS_PER_ROUND(DUCKS), .PASS_HITS(PASS),
    .FLIGHT_FRAMES(FLIGHT), .PAUSE_FRAMES(PAUSE), .SPEED_INIT(SPD_INIT),
    .SPEED_STEP(SPD_STEP), .SPEED_MAX(SPD_MAX), .HIT_POINTS(HIT_POINTS)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .trigger(trigger),
    .detect(detect), .duck_landed(duck_landed), .flash(flash),
    .duck_fly(duck_fly), .duck_spawn(duck_spawn), .duck_shot(duck_shot),
    .duck_escape(duck_escape), .speed(speed), .shots_left(shots_left),
    .hits(hits), .duck_idx(duck_idx), .round(round), .score(score),
    .game_over(game_over)
  );

  typedef struct {
    logic [2:0]  ev;
    logic [15:0] score;
    logic [3:0]  hits;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model of the game bookkeeping
  int m_score, m_hits, m_idx, m_round, m_speed, m_shots, m_over;

  logic [2:0] mon_obs;
  exp_t       mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] ev);
    exp_t e;
    e.ev    = ev;
    e.score = 16'(m_score);
    e.hits  = 4'(m_hits);
    e.idx   = 4'(m_idx);
    exp_q.push_back(e);
  endtask

  // One frame: inputs settle one clk before a single-clk frame_tick.
  task automatic do_tick(input logic trig, input logic det, input logic land);
    @(negedge clk);
    trigger = trig; detect = det; duck_landed = land;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Edge frame -> BLACK -> WHITE -> verdict.
  task automatic shoot(input logic hit);
    m_shots--;
    do_tick(1'b1, 1'b0, 1'b0);
    check("black_flash", 32'(flash), 32'(2'b01));
    check("shots_left", 32'(shots_left), 32'(m_shots));
    do_tick(1'b0, 1'b0, 1'b0);
    check("white_flash", 32'(flash), 32'(2'b10));
    if (hit) begin
      m_hits++;
      m_score += HIT_POINTS;
      if (m_score > 65535) m_score = 65535;
      push(EV_SHOT);
    end else if (m_shots == 0) begin
      push(EV_ESC);
    end
    do_tick(1'b0, hit, 1'b0);
    check("verdict_flash", 32'(flash), 32'(0));
    check("verdict_fly", 32'(duck_fly), 32'(!hit && m_shots != 0));
  endtask

  task automatic pause_out();
    for (int i = 1; i < PAUSE; i++) do_tick(1'b0, 1'b0, 1'b0);
    if (m_idx < DUCKS - 1) begin
      m_idx++;
      m_shots = SHOTS;
      push(EV_SPAWN);
    end else if (m_hits >= PASS) begin
      m_round++;
      m_speed = (m_speed + SPD_STEP > SPD_MAX) ? SPD_MAX : m_speed + SPD_STEP;
      m_hits = 0;
      m_idx = 0;
      m_shots = SHOTS;
      push(EV_SPAWN);
    end else begin
      m_over = 1;
    end
    do_tick(1'b0, 1'b0, 1'b0);
    check("pause_game_over", 32'(game_over), 32'(m_over));
    check("pause_round", 32'(round), 32'(m_round));
    check("pause_speed", 32'(speed), 32'(m_speed));
    check("pause_idx", 32'(duck_idx), 32'(m_idx));
  endtask

  task automatic hit_duck();
    shoot(1'b1);
    do_tick(1'b0, 1'b0, 1'b1);
    pause_out();
  endtask

  task automatic miss_duck();
    shoot(1'b0);
    shoot(1'b0);
    shoot(1'b0);
    pause_out();
  endtask

  // Event monitor: each pulse pops one expected event.
  always @(negedge clk) begin
    mon_obs = {duck_spawn, duck_shot, duck_escape};
    if (mon_obs !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(mon_obs), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("event", 32'(mon_obs), 32'(mon_e.ev));
        check("event_score", 32'(score), 32'(mon_e.score));
        check("event_hits", 32'(hits), 32'(mon_e.hits));
        check("event_idx", 32'(duck_idx), 32'(mon_e.idx));
        $display("event %b score=%0d hits=%0d idx=%0d", mon_obs, score, hits, duck_idx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; trigger = 1'b0; detect = 1'b0; duck_landed = 1'b0;
    m_score = 0; m_hits = 0; m_idx = 0; m_round = 0; m_speed = SPD_INIT;
    m_shots = 0; m_over = 0;
    repeat (2) @(negedge clk);
    // Reset must override a frame_tick with a trigger present
    trigger = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; trigger = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_flash", 32'(flash), 32'(0));
    check("rst_fly", 32'(duck_fly), 32'(0));
    check("rst_shots", 32'(shots_left), 32'(0));
    check("rst_hits", 32'(hits), 32'(0));
    check("rst_idx", 32'(duck_idx), 32'(0));
    check("rst_round", 32'(round), 32'(0));
    check("rst_score", 32'(score), 32'(0));
    check("rst_speed", 32'(speed), 32'(SPD_INIT));
    check("rst_game_over", 32'(game_over), 32'(0));

    // Idle frame without trigger stays idle
    do_tick(1'b0, 1'b0, 1'b0);
    check("idle_fly", 32'(duck_fly), 32'(0));

    // Start the game
    m_score = 0; m_hits = 0; m_idx = 0; m_round = 1; m_speed = SPD_INIT; m_shots = SHOTS;
    push(EV_SPAWN);
    do_tick(1'b1, 1'b0, 1'b0);
    check("start_shots", 32'(shots_left), 32'(SHOTS));
    check("start_fly", 32'(duck_fly), 32'(1));
    check("start_round", 32'(round), 32'(1));
    do_tick(1'b0, 1'b0, 1'b0);

    // Round 1, duck 0: hit
    hit_duck();
    check("duck1_shots", 32'(shots_left), 32'(SHOTS));

    // Duck 1: three misses then escape
    miss_duck();

    // Duck 2: flight timeout
    repeat (FLIGHT - 1) do_tick(1'b0, 1'b0, 1'b0);
    check("timeout_pre_fly", 32'(duck_fly), 32'(1));
    push(EV_ESC);
    do_tick(1'b0, 1'b0, 1'b0);
    check("timeout_fly", 32'(duck_fly), 32'(0));
    check("timeout_flash", 32'(flash), 32'(0));
    pause_out();

    // Duck 3: shot on the timeout tick wins
    repeat (FLIGHT - 1) do_tick(1'b0, 1'b0, 1'b0);
    hit_duck();

    // Duck 4: trigger held for 20 frames gives one shot only
    m_shots--;
    do_tick(1'b1, 1'b0, 1'b0);
    check("held_black", 32'(flash), 32'(2'b01));
    do_tick(1'b1, 1'b0, 1'b0);
    check("held_white", 32'(flash), 32'(2'b10));
    do_tick(1'b1, 1'b0, 1'b0);
    repeat (17) do_tick(1'b1, 1'b0, 1'b0);
    check("held_shots", 32'(shots_left), 32'(m_shots));
    check("held_flash", 32'(flash), 32'(0));
    check("held_fly", 32'(duck_fly), 32'(1));
    do_tick(1'b0, 1'b0, 1'b0);
    hit_duck();

    // Ducks 5..7 hit, 8..9 escape: 6 hits passes the round
    repeat (3) hit_duck();
    repeat (2) miss_duck();
    check("pass_round", 32'(round), 32'(2));
    check("pass_speed", 32'(speed), 32'(SPD_INIT + SPD_STEP));
    check("pass_hits", 32'(hits), 32'(0));

    // Round 2: 5 hits fails
    repeat (5) hit_duck();
    repeat (5) miss_duck();
    check("over_flag", 32'(game_over), 32'(1));
    check("over_score", 32'(score), 32'(11 * HIT_POINTS));
    check("over_hits", 32'(hits), 32'(5));
    repeat (3) do_tick(1'b0, 1'b0, 1'b0);
    check("over_hold", 32'(game_over), 32'(1));
    do_tick(1'b1, 1'b0, 1'b0);
    check("over_exit", 32'(game_over), 32'(0));
    check("over_exit_score", 32'(score), 32'(11 * HIT_POINTS));
    check("over_exit_fly", 32'(duck_fly), 32'(0));
    do_tick(1'b0, 1'b0, 1'b0);

    // Restart, score a hit, then reset during WHITE with detect high
    m_score = 0; m_hits = 0; m_idx = 0; m_round = 1; m_speed = SPD_INIT; m_shots = SHOTS; m_over = 0;
    push(EV_SPAWN);
    do_tick(1'b1, 1'b0, 1'b0);
    check("restart_round", 32'(round), 32'(1));
    check("restart_speed", 32'(speed), 32'(SPD_INIT));
    check("restart_score", 32'(score), 32'(0));
    do_tick(1'b0, 1'b0, 1'b0);
    hit_duck();
    check("restart_hit_score", 32'(score), 32'(HIT_POINTS));
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    check("midwhite_flash", 32'(flash), 32'(2'b10));
    @(negedge clk);
    detect = 1'b1;
    @(negedge clk);
    rst = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0; detect = 1'b0; trigger = 1'b0;
    check("midrst_flash", 32'(flash), 32'(0));
    check("midrst_score", 32'(score), 32'(0));
    check("midrst_hits", 32'(hits), 32'(0));
    check("midrst_shots", 32'(shots_left), 32'(0));
    check("midrst_round", 32'(round), 32'(0));
    check("midrst_fly", 32'(duck_fly), 32'(0));

    // Back in IDLE: a fresh edge spawns a new game
    do_tick(1'b0, 1'b0, 1'b0);
    m_score = 0; m_hits = 0; m_idx = 0; m_round = 1; m_speed = SPD_INIT; m_shots = SHOTS;
    push(EV_SPAWN);
    do_tick(1'b1, 1'b0, 1'b0);
    check("post_rst_fly", 32'(duck_fly), 32'(1));
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
